// File: rtl/ball_collision_detect.sv
`default_nettype none
// ============================================================================
//  Module   : ball_collision_detect
//  Purpose  : Pixel-coincidence collision detector for the ball game. It
//             watches per-pixel draw requests during a frame, latches sticky
//             hit flags, and on the frame boundary reports at most one ball
//             hit (shot vs. ball) plus a player hit as one-cycle pulses. It
//             also keeps a player invulnerability counter and a saturating
//             count of reported ball hits.
//  Ports    :
//    clk             in   pixel clock, rising edge
//    resetN          in   asynchronous active-low reset
//    startOfFrame    in   one-cycle frame-boundary pulse (REPORT event)
//    gameActive      in   enables detection and reporting
//    hugeBallRequest in   huge ball pixel drawing
//    bigBall1Request in   big ball 1 pixel drawing
//    bigBall2Request in   big ball 2 pixel drawing
//    ballRequest     in   OR of all ball requests
//    shotRequest     in   shot (rope) pixel drawing
//    playerRequest   in   player pixel drawing
//    hugeBallHit     out  pulse: shot hit huge ball last frame
//    bigBall1Hit     out  pulse: shot hit big ball 1 last frame
//    bigBall2Hit     out  pulse: shot hit big ball 2 last frame
//    shotConsumed    out  pulse with any ball hit pulse
//    playerHit       out  pulse: player touched a ball last frame
//    invulnerable    out  high while invulnerability counter nonzero
//    hitCount[7:0]   out  reported ball hits since reset, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module ball_collision_detect #(
    parameter int INVULN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       gameActive,
    input  logic       hugeBallRequest,
    input  logic       bigBall1Request,
    input  logic       bigBall2Request,
    input  logic       ballRequest,
    input  logic       shotRequest,
    input  logic       playerRequest,
    output logic       hugeBallHit,
    output logic       bigBall1Hit,
    output logic       bigBall2Hit,
    output logic       shotConsumed,
    output logic       playerHit,
    output logic       invulnerable,
    output logic [7:0] hitCount
);

    localparam logic [7:0] c_INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam logic [7:0] c_COUNT_MAX   = 8'hFF;

    // Sticky per-frame flags
    logic fHuge_q, fHuge_d;
    logic fBig1_q, fBig1_d;
    logic fBig2_q, fBig2_d;
    logic fPlayer_q, fPlayer_d;

    // Registered outputs
    logic       hugeHit_q, hugeHit_d;
    logic       big1Hit_q, big1Hit_d;
    logic       big2Hit_q, big2Hit_d;
    logic       consumed_q, consumed_d;
    logic       playerHit_q, playerHit_d;
    logic       invuln_q, invuln_d;
    logic [7:0] invCnt_q, invCnt_d;
    logic [7:0] hitCnt_q, hitCnt_d;

    // Same-cycle coincidences; the player test is masked while invulnerable
    logic w_cHuge, w_cBig1, w_cBig2, w_cPlayer;
    // Reporting decisions for this REPORT edge
    logic w_report, w_repHuge, w_repBig1, w_repBig2, w_repBall, w_repPlayer;

    assign w_cHuge   = gameActive & shotRequest & hugeBallRequest;
    assign w_cBig1   = gameActive & shotRequest & bigBall1Request;
    assign w_cBig2   = gameActive & shotRequest & bigBall2Request;
    assign w_cPlayer = gameActive & ~invuln_q & playerRequest & ballRequest;

    // Reporting only happens when the game is running; an inactive frame
    // boundary still clears the flags (see flag next-state below).
    assign w_report    = startOfFrame & gameActive;
    // One ball hit per frame, same priority as drawing: big1 > big2 > huge
    assign w_repBig1   = w_report & fBig1_q;
    assign w_repBig2   = w_report & fBig2_q & ~fBig1_q;
    assign w_repHuge   = w_report & fHuge_q & ~fBig1_q & ~fBig2_q;
    assign w_repBall   = w_repBig1 | w_repBig2 | w_repHuge;
    assign w_repPlayer = w_report & fPlayer_q;

    always_comb begin
        // On the frame boundary the old flags are dropped and only the
        // coincidence in the boundary cycle itself seeds the new frame.
        if (startOfFrame) begin
            fHuge_d   = w_cHuge;
            fBig1_d   = w_cBig1;
            fBig2_d   = w_cBig2;
            fPlayer_d = w_cPlayer;
        end else begin
            fHuge_d   = fHuge_q   | w_cHuge;
            fBig1_d   = fBig1_q   | w_cBig1;
            fBig2_d   = fBig2_q   | w_cBig2;
            fPlayer_d = fPlayer_q | w_cPlayer;
        end

        hugeHit_d   = w_repHuge;
        big1Hit_d   = w_repBig1;
        big2Hit_d   = w_repBig2;
        consumed_d  = w_repBall;
        playerHit_d = w_repPlayer;

        invCnt_d = invCnt_q;
        if (w_repPlayer) begin
            invCnt_d = c_INVULN_LOAD;
        end else if (w_report && (invCnt_q != 8'd0)) begin
            invCnt_d = invCnt_q - 8'd1;
        end
        invuln_d = (invCnt_d != 8'd0);

        hitCnt_d = hitCnt_q;
        if (w_repBall && (hitCnt_q != c_COUNT_MAX)) begin
            hitCnt_d = hitCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fHuge_q     <= 1'b0;
            fBig1_q     <= 1'b0;
            fBig2_q     <= 1'b0;
            fPlayer_q   <= 1'b0;
            hugeHit_q   <= 1'b0;
            big1Hit_q   <= 1'b0;
            big2Hit_q   <= 1'b0;
            consumed_q  <= 1'b0;
            playerHit_q <= 1'b0;
            invuln_q    <= 1'b0;
            invCnt_q    <= 8'd0;
            hitCnt_q    <= 8'd0;
        end else begin
            fHuge_q     <= fHuge_d;
            fBig1_q     <= fBig1_d;
            fBig2_q     <= fBig2_d;
            fPlayer_q   <= fPlayer_d;
            hugeHit_q   <= hugeHit_d;
            big1Hit_q   <= big1Hit_d;
            big2Hit_q   <= big2Hit_d;
            consumed_q  <= consumed_d;
            playerHit_q <= playerHit_d;
            invuln_q    <= invuln_d;
            invCnt_q    <= invCnt_d;
            hitCnt_q    <= hitCnt_d;
        end
    end

    assign hugeBallHit  = hugeHit_q;
    assign bigBall1Hit  = big1Hit_q;
    assign bigBall2Hit  = big2Hit_q;
    assign shotConsumed = consumed_q;
    assign playerHit    = playerHit_q;
    assign invulnerable = invuln_q;
    assign hitCount     = hitCnt_q;

endmodule
`default_nettype wire
